alu_exec_unit: RTL and testbench

//  Parametrised successor to the MIPS ALU control decode. It decodes ALU_OP/funct,

---
 rtl/alu_exec_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with MIPS-style ALU_OP/funct decode, iterative unsigned
// multiply/divide into HI/LO, and a registered result behind a valid/ready handshake.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake; ALU_OP, In (funct), a, b captured on accept
//   out_valid / out_ready result handshake; result, zero, overflow, illegal held until taken
//   hi, lo                architectural HI/LO registers
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALU_OP,
  input  logic [5:0]       In,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnXor   = 6'b100110;
  localparam logic [5:0] FnNor   = 6'b100111;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDivu  = 6'b011011;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;
  typedef enum logic [1:0] {KindAlu, KindMul, KindDiv, KindDivZero} kind_e;

  state_e             r_state, w_state_nxt;
  logic [CntW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_work_hi, w_work_hi_nxt;  // mul: upper accumulator; div: remainder
  logic [WIDTH-1:0]   r_work_lo, w_work_lo_nxt;  // mul: multiplier/low product; div: quotient
  logic [WIDTH-1:0]   r_opnd, w_opnd_nxt;        // mul: multiplicand; div: divisor
  logic [WIDTH-1:0]   r_result, w_result_nxt;
  logic [WIDTH-1:0]   r_hi, w_hi_nxt;
  logic [WIDTH-1:0]   r_lo, w_lo_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic               r_zero, w_zero_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_ill, w_ill_nxt;

  logic               w_slot_free, w_accept, w_iter_done;
  logic [WIDTH-1:0]   w_sum, w_diff, w_alu_res;
  logic               w_add_ovf, w_sub_ovf, w_alu_ovf, w_alu_ill;
  kind_e              w_kind;
  logic [WIDTH:0]     w_mul_sum, w_div_shift;
  logic               w_div_ge;

  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = (r_state == StIdle) && w_slot_free;
  assign w_accept    = in_valid && in_ready;
  assign w_iter_done = (r_cnt == CntW'(WIDTH));

  assign w_sum     = a + b;
  assign w_diff    = a - b;
  assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
  assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

  // Shift-add step: add multiplicand when the current multiplier bit is set, then shift
  // the {accumulator, multiplier} pair right; after WIDTH steps it holds the product.
  assign w_mul_sum = {1'b0, r_work_hi} + (r_work_lo[0] ? {1'b0, r_opnd} : '0);

  // Restoring divide step: bring down the next dividend bit and subtract if it fits.
  assign w_div_shift = {r_work_hi, r_work_lo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});

  always_comb begin
    w_kind    = KindAlu;
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    w_alu_ill = 1'b0;
    unique case (ALU_OP)
      2'b00: begin w_alu_res = w_sum;  w_alu_ovf = w_add_ovf; end
      2'b01: begin w_alu_res = w_diff; w_alu_ovf = w_sub_ovf; end
      2'b10: begin
        case (In)
          FnAdd:   begin w_alu_res = w_sum;  w_alu_ovf = w_add_ovf; end
          FnSub:   begin w_alu_res = w_diff; w_alu_ovf = w_sub_ovf; end
          FnAnd:   w_alu_res = a & b;
          FnOr:    w_alu_res = a | b;
          FnXor:   w_alu_res = a ^ b;
          FnNor:   w_alu_res = ~(a | b);
          FnSlt:   w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          FnMfhi:  w_alu_res = r_hi;
          FnMflo:  w_alu_res = r_lo;
          FnMultu: w_kind = KindMul;
          FnDivu:  w_kind = (b == '0) ? KindDivZero : KindDiv;
          default: w_alu_ill = 1'b1;
        endcase
      end
      default: w_alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_work_hi_nxt   = r_work_hi;
    w_work_lo_nxt   = r_work_lo;
    w_opnd_nxt      = r_opnd;
    w_result_nxt    = r_result;
    w_hi_nxt        = r_hi;
    w_lo_nxt        = r_lo;
    w_zero_nxt      = r_zero;
    w_ovf_nxt       = r_ovf;
    w_ill_nxt       = r_ill;
    w_out_valid_nxt = r_out_valid && !out_ready;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          unique case (w_kind)
            KindAlu: begin
              w_result_nxt    = w_alu_res;
              w_zero_nxt      = (w_alu_res == '0);
              w_ovf_nxt       = w_alu_ovf;
              w_ill_nxt       = w_alu_ill;
              w_out_valid_nxt = 1'b1;
            end
            KindDivZero: begin
              w_result_nxt    = '1;
              w_lo_nxt        = '1;
              w_hi_nxt        = a;
              w_zero_nxt      = 1'b0;
              w_ovf_nxt       = 1'b0;
              w_ill_nxt       = 1'b0;
              w_out_valid_nxt = 1'b1;
            end
            KindMul: begin
              w_work_hi_nxt = '0;
              w_work_lo_nxt = b;
              w_opnd_nxt    = a;
              w_cnt_nxt     = '0;
              w_state_nxt   = StMul;
            end
            KindDiv: begin
              w_work_hi_nxt = '0;
              w_work_lo_nxt = a;
              w_opnd_nxt    = b;
              w_cnt_nxt     = '0;
              w_state_nxt   = StDiv;
            end
          endcase
        end
      end
      StMul, StDiv: begin
        if (!w_iter_done) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_state == StMul) begin
            w_work_hi_nxt = w_mul_sum[WIDTH:1];
            w_work_lo_nxt = {w_mul_sum[0], r_work_lo[WIDTH-1:1]};
          end else begin
            w_work_hi_nxt = w_div_ge ? WIDTH'(w_div_shift - {1'b0, r_opnd})
                                     : w_div_shift[WIDTH-1:0];
            w_work_lo_nxt = {r_work_lo[WIDTH-2:0], w_div_ge};
          end
        end else if (w_slot_free) begin
          // Commit only once the output slot is free so a held result is never overwritten.
          w_hi_nxt        = r_work_hi;
          w_lo_nxt        = r_work_lo;
          w_result_nxt    = r_work_lo;
          w_zero_nxt      = (r_work_lo == '0);
          w_ovf_nxt       = 1'b0;
          w_ill_nxt       = 1'b0;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_work_hi   <= '0;
      r_work_lo   <= '0;
      r_opnd      <= '0;
      r_result    <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_ill       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_work_hi   <= w_work_hi_nxt;
      r_work_lo   <= w_work_lo_nxt;
      r_opnd      <= w_opnd_nxt;
      r_result    <= w_result_nxt;
      r_hi        <= w_hi_nxt;
      r_lo        <= w_lo_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_zero      <= w_zero_nxt;
      r_ovf       <= w_ovf_nxt;
      r_ill       <= w_ill_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign overflow  = r_ovf;
  assign illegal   = r_ill;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam int unsigned W = 32;

  logic         clk, reset, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] a, b, result, hi, lo;
  logic         zero, overflow, illegal;

  int n_checks = 0;
  int n_pass   = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_OP(alu_op), .In(funct), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .illegal(illegal), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op for exactly one edge; sampling happens 1 ns after that edge.
  task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                       input logic [W-1:0] va, input logic [W-1:0] vb);
    alu_op = op; funct = fn; a = va; b = vb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; funct = 6'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0 || overflow !== 1'b0 ||
        illegal !== 1'b0) $display("FAIL reset_outputs: ov=%b res=%h z=%b ovf=%b ill=%b required 0",
                                   out_valid, result, zero, overflow, illegal);
    else n_pass++;
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL reset_hilo: hi=%h lo=%h required 0", hi, lo);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    issue(2'b00, 6'd0, 32'd5, 32'd7);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'd12 || zero !== 1'b0 || overflow !== 1'b0)
      $display("FAIL lw_add: ov=%b res=%h z=%b ovf=%b required 1/0000000c/0/0",
               out_valid, result, zero, overflow);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL drain: out_valid=%b required 0", out_valid);
    else n_pass++;
    issue(2'b01, 6'd0, 32'd5, 32'd5);
    n_checks++;
    if (result !== 32'd0 || zero !== 1'b1) $display("FAIL beq_sub: res=%h z=%b required 0/1",
                                                     result, zero);
    else n_pass++;
  endtask

  task automatic test_rtype();
    issue(2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1);
    n_checks++;
    if (result !== 32'h8000_0000 || overflow !== 1'b1)
      $display("FAIL add_ovf: res=%h ovf=%b required 80000000/1", result, overflow);
    else n_pass++;
    issue(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
    n_checks++;
    if (result !== 32'd1 || overflow !== 1'b0 || zero !== 1'b0)
      $display("FAIL slt: res=%h ovf=%b z=%b required 1/0/0", result, overflow, zero);
    else n_pass++;
  endtask

  // Consecutive single-cycle ops with in_valid held high: one result per clock.
  task automatic test_back_to_back();
    logic [5:0]   fn_t [6] = '{6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b100010, 6'b100010};
    logic [W-1:0] a_t  [6] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                               32'd3, 32'h8000_0000};
    logic [W-1:0] b_t  [6] = '{32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
                               32'd5, 32'd1};
    logic [W-1:0] r_t  [6] = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h000F000F,
                               32'hFFFFFFFE, 32'h7FFFFFFF};
    logic         v_t  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      alu_op = 2'b10; funct = fn_t[i]; a = a_t[i]; b = b_t[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || result !== r_t[i] || overflow !== v_t[i])
        $display("FAIL stream_%0d: ov=%b res=%h ovf=%b required 1/%h/%b",
                 i, out_valid, result, overflow, r_t[i], v_t[i]);
      else n_pass++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Wait for out_valid after a mul/div accept; in_ready must stay low meanwhile while
  // garbage is driven on the inputs.
  task automatic wait_iter(input string name, output int lat);
    logic busy_ok = 1'b1;
    lat = -1;
    alu_op = 2'b11; funct = 6'b111111; a = 32'hDEAD; b = 32'hBEEF; in_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin lat = k; break; end
      if (in_ready !== 1'b0) busy_ok = 1'b0;
    end
    in_valid = 1'b0;
    n_checks++;
    if (lat != 33) $display("FAIL %s_latency: got %0d required 33", name, lat);
    else n_pass++;
    n_checks++;
    if (!busy_ok) $display("FAIL %s_in_ready: went high while busy, required 0", name);
    else n_pass++;
  endtask

  task automatic test_mul();
    int lat;
    issue(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'd2);
    wait_iter("multu", lat);
    n_checks++;
    if (hi !== 32'd1 || lo !== 32'hFFFF_FFFE || result !== 32'hFFFF_FFFE)
      $display("FAIL multu_value: hi=%h lo=%h res=%h required 1/fffffffe/fffffffe",
               hi, lo, result);
    else n_pass++;
    issue(2'b10, 6'b010000, 32'd0, 32'd0);
    n_checks++;
    if (result !== 32'd1) $display("FAIL mfhi: res=%h required 1", result);
    else n_pass++;
    issue(2'b10, 6'b010010, 32'd0, 32'd0);
    n_checks++;
    if (result !== 32'hFFFF_FFFE) $display("FAIL mflo: res=%h required fffffffe", result);
    else n_pass++;
  endtask

  task automatic test_div();
    int lat;
    issue(2'b10, 6'b011011, 32'd100, 32'd7);
    wait_iter("divu", lat);
    n_checks++;
    if (lo !== 32'd14 || hi !== 32'd2 || result !== 32'd14)
      $display("FAIL divu_value: hi=%h lo=%h res=%h required 2/e/e", hi, lo, result);
    else n_pass++;
    issue(2'b10, 6'b011011, 32'd9, 32'd0);
    n_checks++;
    if (out_valid !== 1'b1 || lo !== 32'hFFFF_FFFF || hi !== 32'd9 ||
        result !== 32'hFFFF_FFFF || illegal !== 1'b0 || zero !== 1'b0)
      $display("FAIL divu_by_zero: ov=%b hi=%h lo=%h res=%h ill=%b z=%b required 1/9/ffffffff/ffffffff/0/0",
               out_valid, hi, lo, result, illegal, zero);
    else n_pass++;
  endtask

  task automatic test_illegal();
    issue(2'b11, 6'b100000, 32'd1, 32'd2);
    n_checks++;
    if (illegal !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0 ||
        hi !== 32'd9 || lo !== 32'hFFFF_FFFF)
      $display("FAIL illegal_aluop: ill=%b res=%h z=%b ovf=%b hi=%h lo=%h required 1/0/1/0/9/ffffffff",
               illegal, result, zero, overflow, hi, lo);
    else n_pass++;
    issue(2'b10, 6'b111111, 32'd1, 32'd2);
    n_checks++;
    if (illegal !== 1'b1 || result !== 32'd0 || zero !== 1'b1 ||
        hi !== 32'd9 || lo !== 32'hFFFF_FFFF)
      $display("FAIL illegal_funct: ill=%b res=%h z=%b hi=%h lo=%h required 1/0/1/9/ffffffff",
               illegal, result, zero, hi, lo);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    issue(2'b10, 6'b011001, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
      $display("FAIL abort_state: ov=%b hi=%h lo=%h required 0/0/0", out_valid, hi, lo);
    else n_pass++;
    @(posedge clk); #1 reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL abort_in_ready: got %b required 1", in_ready);
    else n_pass++;
    repeat (40) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || lo !== 32'd0) $display("FAIL abort_no_result: ov=%b lo=%h required 0/0",
                                                     out_valid, lo);
    else n_pass++;
  endtask

  task automatic test_hold();
    logic stable = 1'b1;
    out_ready = 1'b0;
    issue(2'b00, 6'd0, 32'd2, 32'd3);
    // A competing op stays on the inputs; it must not be taken while the slot is full.
    alu_op = 2'b10; funct = 6'b100010; a = 32'd4; b = 32'd4; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (out_valid !== 1'b1 || result !== 32'd5 || zero !== 1'b0 || overflow !== 1'b0 ||
          illegal !== 1'b0 || in_ready !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++;
    if (!stable) $display("FAIL hold_stable: ov=%b res=%h z=%b rdy=%b required 1/5/0/0",
                          out_valid, result, zero, in_ready);
    else n_pass++;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL hold_release_ready: got %b required 1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1)
      $display("FAIL hold_next_op: ov=%b res=%h z=%b required 1/0/1", out_valid, result, zero);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_rtype();
    test_back_to_back();
    test_mul();
    test_div();
    test_illegal();
    test_reset_abort();
    test_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
